parking_ctrl_n: RTL and testbench

PARKING_CTRL_N -- requirements
Module: parking_ctrl_n

---
 rtl/parking_ctrl_n.sv | 130 +++++++++++++
 tb/tb_parking_ctrl_n.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/parking_ctrl_n.sv
// Parking lot controller: slot allocation bitmap, free-slot count,
// request edge detection and a timed gate-open FSM.
module parking_ctrl_n #(
    parameter int SLOTS     = 8,
    parameter int DOOR_HOLD = 3,
    localparam int SW = $clog2(SLOTS),
    localparam int CW = $clog2(SLOTS + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          enter,
    input  logic          exit,
    input  logic [SW-1:0] switch,
    output logic          full,
    output logic          empty,
    output logic          door_open,
    output logic [CW-1:0] capacity,
    output logic [SW-1:0] L,
    output logic [SLOTS-1:0] occ,
    output logic          rej
);

    localparam int DW = (DOOR_HOLD < 1) ? 1 : $clog2(DOOR_HOLD + 1);

    typedef enum logic {CLOSED = 1'b0, OPEN = 1'b1} door_t;

    door_t         state;
    logic [DW-1:0] cnt;
    logic          enter_q;
    logic          exit_q;

    logic          enter_rise;
    logic          exit_rise;
    logic          enter_ok;
    logic          exit_ok;
    logic          exit_sel;
    logic          exit_valid;
    logic          has_free;
    logic [SW-1:0] free_idx;
    logic [SLOTS-1:0] occ_n;
    logic [CW-1:0] cap_n;
    logic          accepted;

    assign enter_rise = enter & ~enter_q;
    assign exit_rise  = exit & ~exit_q;
    assign has_free   = ~&occ;

    // Decisions use the pre-update bitmap, so a slot vacated this cycle
    // still looks taken to a simultaneous arrival.
    always_comb begin
        free_idx   = '0;
        exit_sel   = 1'b0;
        exit_valid = 1'b0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!occ[i]) free_idx = SW'(i);
        end
        for (int i = 0; i < SLOTS; i++) begin
            if (switch == SW'(i)) begin
                exit_sel   = occ[i];
                exit_valid = 1'b1;
            end
        end
    end

    assign enter_ok = enter_rise & has_free;
    assign exit_ok  = exit_rise & exit_valid & exit_sel;
    assign accepted = enter_ok | exit_ok;

    always_comb begin
        occ_n = occ;
        for (int i = 0; i < SLOTS; i++) begin
            if (enter_ok && free_idx == SW'(i)) occ_n[i] = 1'b1;
            if (exit_ok && switch == SW'(i)) occ_n[i] = 1'b0;
        end
    end

    assign cap_n = capacity + CW'(exit_ok) - CW'(enter_ok);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            enter_q  <= 1'b0;
            exit_q   <= 1'b0;
            occ      <= '0;
            capacity <= CW'(SLOTS);
            L        <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rej      <= 1'b0;
        end else begin
            enter_q  <= enter;
            exit_q   <= exit;
            occ      <= occ_n;
            capacity <= cap_n;
            full     <= (cap_n == '0);
            empty    <= (cap_n == CW'(SLOTS));
            rej      <= (enter_rise & ~enter_ok) | (exit_rise & ~exit_ok);
            if (enter_ok) L <= free_idx;
        end
    end

    // Gate timer: every accepted request restarts the hold window.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= CLOSED;
            cnt       <= '0;
            door_open <= 1'b0;
        end else if (accepted) begin
            state     <= OPEN;
            cnt       <= DW'(DOOR_HOLD);
            door_open <= 1'b1;
        end else begin
            case (state)
                OPEN: begin
                    if (cnt <= DW'(1)) begin
                        state     <= CLOSED;
                        cnt       <= '0;
                        door_open <= 1'b0;
                    end else begin
                        cnt <= cnt - DW'(1);
                    end
                end
                default: begin
                    cnt       <= '0;
                    door_open <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_ctrl_n.sv
// Directed bench for parking_ctrl_n (SLOTS=4, DOOR_HOLD=3) with a
// behavioural reference model compared on every falling clock edge.
module tb_parking_ctrl_n;

    localparam int SLOTS = 4;
    localparam int HOLD  = 3;

    logic       CLK = 1'b0;
    logic       RST;
    logic       enter;
    logic       exit;
    logic [1:0] switch;
    logic       full;
    logic       empty;
    logic       door_open;
    logic [2:0] capacity;
    logic [1:0] L;
    logic [3:0] occ;
    logic       rej;

    int checks = 0;
    int errors = 0;

    parking_ctrl_n #(.SLOTS(SLOTS), .DOOR_HOLD(HOLD)) dut (
        .CLK(CLK), .RST(RST), .enter(enter), .exit(exit),
        .switch(switch), .full(full), .empty(empty),
        .door_open(door_open), .capacity(capacity), .L(L),
        .occ(occ), .rej(rej)
    );

    always #5 CLK = ~CLK;

    // Reference model: slots as a bit array, door as remaining-cycles count.
    logic [3:0] m_occ;
    int         m_L;
    bit         m_rej;
    int         m_left;
    bit         m_pe;
    bit         m_px;
    bit         er, xr, eok, xok;
    int         pick;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_occ = '0; m_L = 0; m_rej = 0; m_left = 0; m_pe = 0; m_px = 0;
        end else begin
            er  = enter && !m_pe;
            xr  = exit && !m_px;
            eok = er && ($countones(m_occ) < SLOTS);
            xok = xr && (int'(switch) < SLOTS) && m_occ[switch];
            pick = -1;
            for (int i = 0; i < SLOTS; i++)
                if (pick < 0 && !m_occ[i]) pick = i;
            if (xok) m_occ[switch] = 1'b0;
            if (eok) begin
                m_occ[pick] = 1'b1;
                m_L = pick;
            end
            m_rej = (er && !eok) || (xr && !xok);
            if (eok || xok) m_left = HOLD;
            else if (m_left > 0) m_left = m_left - 1;
            m_pe = enter;
            m_px = exit;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        automatic int cap = SLOTS - $countones(m_occ);
        chk("occ", int'(occ), int'(m_occ));
        chk("capacity", int'(capacity), cap);
        chk("full", int'(full), int'(cap == 0));
        chk("empty", int'(empty), int'(cap == SLOTS));
        chk("L", int'(L), m_L);
        chk("rej", int'(rej), int'(m_rej));
        chk("door_open", int'(door_open), int'(m_left > 0));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic req(input logic e, input logic x, input logic [1:0] s);
        enter = e; exit = x; switch = s;
        cyc(1);
        enter = 1'b0; exit = 1'b0;
    endtask

    initial begin
        RST = 1'b1; enter = 1'b0; exit = 1'b0; switch = '0;
        cyc(2);
        chk("rst_occ", int'(occ), 0);
        chk("rst_cap", int'(capacity), 4);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_door", int'(door_open), 0);
        RST = 1'b0;
        cyc(1);

        for (int i = 0; i < 4; i++) begin
            req(1, 0, 0);
            chk("alloc_L", int'(L), i);
            chk("alloc_cap", int'(capacity), 3 - i);
            chk("alloc_door", int'(door_open), 1);
            cyc(2);
            chk("door_hold", int'(door_open), 1);
            cyc(1);
            chk("door_closed", int'(door_open), 0);
            cyc(1);
        end
        chk("full_set", int'(full), 1);

        req(1, 0, 0);
        chk("full_rej", int'(rej), 1);
        chk("full_occ", int'(occ), 4'b1111);
        chk("full_door", int'(door_open), 0);
        cyc(1);
        chk("rej_one", int'(rej), 0);
        cyc(3);

        req(0, 1, 1);
        chk("exit_occ", int'(occ), 4'b1101);
        chk("exit_cap", int'(capacity), 1);
        cyc(4);
        req(0, 1, 1);
        chk("exit_rej", int'(rej), 1);
        cyc(4);
        req(1, 0, 0);
        chk("refill_L", int'(L), 1);
        chk("refill_occ", int'(occ), 4'b1111);
        cyc(4);

        req(1, 1, 2);
        chk("both_occ", int'(occ), 4'b1011);
        chk("both_cap", int'(capacity), 1);
        chk("both_rej", int'(rej), 1);
        cyc(1);
        chk("both_rej_one", int'(rej), 0);
        cyc(3);

        enter = 1'b1;
        cyc(10);
        enter = 1'b0;
        chk("held_occ", int'(occ), 4'b1111);
        chk("held_L", int'(L), 2);
        cyc(4);

        req(0, 1, 0);
        cyc(1);
        req(0, 1, 1);
        chk("retrig_occ", int'(occ), 4'b1100);
        cyc(2);
        chk("retrig_open", int'(door_open), 1);
        cyc(1);
        chk("retrig_closed", int'(door_open), 0);
        cyc(2);

        req(0, 1, 3);
        cyc(4);
        req(1, 0, 0);
        cyc(4);
        req(1, 0, 0);
        chk("pre_rst_occ", int'(occ), 4'b0111);
        chk("pre_rst_door", int'(door_open), 1);
        #1 RST = 1'b1;
        #1;
        chk("async_occ", int'(occ), 0);
        chk("async_cap", int'(capacity), 4);
        chk("async_empty", int'(empty), 1);
        chk("async_door", int'(door_open), 0);
        enter = 1'b1;
        cyc(2);
        RST = 1'b0;
        cyc(1);
        chk("rel_occ", int'(occ), 4'b0001);
        chk("rel_L", int'(L), 0);
        enter = 1'b0;
        cyc(4);

        req(0, 1, 2);
        chk("empty_slot_rej", int'(rej), 1);
        cyc(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
